// File: rtl/router_pkg.sv
// Shared types and constants for the router input scheduler.
//   ROUTER_ADDR_W  : width of the router destination address
//   ROUTER_NUM_OUT : number of router outputs (one sink ready per output)
//   sched_state_t  : scheduler FSM state
package router_pkg;
  localparam int ROUTER_ADDR_W  = 2;
  localparam int ROUTER_NUM_OUT = 4;

  typedef enum logic {IDLE, LOCKED} sched_state_t;
endpackage

// File: rtl/router_rr_scheduler_if.sv
// Bundle between the upstream requesters/sinks and the router input scheduler.
//   req_valid/req_data/req_addr/req_last/req_ready : per-requester beat handshake
//   out_ready                                      : per-destination sink ready
//   din/din_en/addr                                : registered beat into the router
//   grant/busy                                     : current owner and lock status
// master: requester/sink side. slave: scheduler side.
interface router_rr_scheduler_if
  import router_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                     req_valid;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_data;
  logic [NUM_REQ-1:0][ROUTER_ADDR_W-1:0]  req_addr;
  logic [NUM_REQ-1:0]                     req_last;
  logic [NUM_REQ-1:0]                     req_ready;
  logic [ROUTER_NUM_OUT-1:0]              out_ready;
  logic [DATA_WIDTH-1:0]                  din;
  logic                                   din_en;
  logic [ROUTER_ADDR_W-1:0]               addr;
  logic [NUM_REQ-1:0]                     grant;
  logic                                   busy;

  modport master (
    output req_valid, req_data, req_addr, req_last, out_ready,
    input  req_ready, din, din_en, addr, grant, busy
  );

  modport slave (
    input  req_valid, req_data, req_addr, req_last, out_ready,
    output req_ready, din, din_en, addr, grant, busy
  );
endinterface

// File: rtl/router_rr_scheduler_rr_arbiter.sv
// Combinational round-robin pick.
//   req   : request vector
//   ptr   : last winner; scan starts at ptr+1 and wraps modulo NUM_REQ
//   grant : one-hot winner (0 if no request)
//   index : winner index
//   any   : at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               any
);
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    index = '0;
    any   = 1'b0;
    // ptr itself is visited last (k == NUM_REQ), so the previous owner has lowest priority
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        index      = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/router_rr_scheduler.sv
// Round-robin scheduler sharing the single router input among NUM_REQ requesters.
// A winner is picked in IDLE, the grant is locked until that requester's last
// beat, and each accepted beat is registered onto din/din_en with the packet's
// destination captured on its first beat. Per-destination out_ready stalls the
// single-entry output stage.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : handshake/router bundle (slave side)
module router_rr_scheduler
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
) (
  input logic clk,
  input logic reset,
  router_rr_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);

  sched_state_t             state;
  logic [NUM_REQ-1:0]       grant_q;
  logic [IW-1:0]            gidx;
  logic [IW-1:0]            rr_ptr;
  logic                     busy_q;
  logic                     first_beat;
  logic [DATA_WIDTH-1:0]    din_q;
  logic                     din_en_q;
  logic [ROUTER_ADDR_W-1:0] addr_q;

  logic [NUM_REQ-1:0]       win_oh;
  logic [IW-1:0]            win_idx;
  logic                     win_any;
  logic                     fire, can_accept, accept;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (win_oh),
    .index (win_idx),
    .any   (win_any)
  );

  // Output stage frees up when empty or when its beat leaves this cycle
  assign fire       = din_en_q && bus.out_ready[addr_q];
  assign can_accept = !din_en_q || fire;
  assign accept     = (state == LOCKED) && can_accept && bus.req_valid[gidx];

  assign bus.req_ready = (state == LOCKED && can_accept) ? grant_q : '0;
  assign bus.din       = din_q;
  assign bus.din_en    = din_en_q;
  assign bus.addr      = addr_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      gidx       <= '0;
      rr_ptr     <= IW'(NUM_REQ - 1);
      busy_q     <= 1'b0;
      first_beat <= 1'b0;
      din_q      <= '0;
      din_en_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      // Output register; a stalled beat simply holds
      if (accept) begin
        din_q    <= bus.req_data[gidx];
        din_en_q <= 1'b1;
        if (first_beat) addr_q <= bus.req_addr[gidx];
      end else if (fire) begin
        din_q    <= '0;
        din_en_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Arbitration runs while a previous packet's final beat may still drain
          if (win_any) begin
            state      <= LOCKED;
            grant_q    <= win_oh;
            gidx       <= win_idx;
            busy_q     <= 1'b1;
            first_beat <= 1'b1;
          end
        end
        LOCKED: begin
          if (accept) begin
            first_beat <= 1'b0;
            if (bus.req_last[gidx]) begin
              state   <= IDLE;
              grant_q <= '0;
              busy_q  <= 1'b0;
              rr_ptr  <= gidx;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/router_rr_scheduler.md
Name: router_rr_scheduler

Overview:
- Shares the single input of the 4-output simple router (din / din_en / addr) between NUM_REQ upstream requesters.
- Requesters present packets over a valid/ready handshake. The block grants one requester at a time in round-robin order and locks the grant until that requester's last beat.
- Each beat is registered and driven into the router with destination addr held for the whole packet; per-destination backpressure stalls the path.

Parameters:
- DATA_WIDTH, 32, beat width; equals the router DATA_WIDTH.
- NUM_REQ, 4, number of requesters, 2..8.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester beat valid
- req_data  input  NUM_REQ*DATA_WIDTH  beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_addr  input  NUM_REQ*2  destination; requester i occupies bits [i*2 +: 2]
- req_last  input  NUM_REQ  last beat of packet
- req_ready  output  NUM_REQ  beat accepted when valid&&ready at a clk edge
- out_ready  input  4  per-destination sink ready; bit k belongs to router output k
- din  output  DATA_WIDTH  to router din
- din_en  output  1  to router din_en
- addr  output  2  to router addr
- grant  output  NUM_REQ  one-hot current owner; 0 when idle
- busy  output  1  high in LOCKED state

Behaviour:
- Reset, synchronous, active-high; all registers cleared at the next clk edge:
  - state=IDLE, grant=0, busy=0, din_en=0, din=0, addr=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has top priority after reset.
- Reset mid-packet discards the held output beat and the lock. Requesters must restart their packet.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If any req_valid is set, the winner is the first set bit scanning from rr_ptr+1 upward, with modulo NUM_REQ wrap.
  - At the next edge: grant=onehot(winner), state=LOCKED.
  - req_ready=0 in IDLE, giving one bubble cycle per arbitration.
- LOCKED, output stage:
  - fire = din_en && out_ready[addr].
  - can_accept = !din_en || fire.
  - req_ready[i] = grant[i] && can_accept. All other req_ready bits are 0.
- LOCKED, accept at an edge where req_valid[g] && req_ready[g]:
  - din <= beat, din_en <= 1.
  - addr <= req_addr[g] on the first beat of the packet only. Later beats' req_addr is ignored and addr holds.
- Fire without accept at an edge: din_en <= 0, din <= 0.
- Stall: while din_en && !out_ready[addr], din, din_en and addr hold stable.
- Latency: accept at edge t, so the beat is visible on din for the cycle after t. Full throughput while the sink is ready.
- Packet end: an accepted beat with req_last[g]=1 causes, at the same edge, state<=IDLE, grant<=0, rr_ptr<=g.
  - The final beat may still be held in the output stage; it drains normally.
  - In IDLE the next arbitration proceeds in parallel, and req_ready stays gated by can_accept once LOCKED again.
- Single-beat packet (last on first beat): grant lasts exactly one accept.
- A granted requester dropping req_valid mid-packet keeps the lock, with no timeout. Other requesters wait.
- Non-granted req_valid never affects outputs.
- din=0 whenever din_en=0, so idle router outputs are all zero.
- Wrap-around: with rr_ptr=NUM_REQ-1, the scan starts at 0.

Decomposition:
- Package router_pkg contains:
  - ROUTER_ADDR_W=2 and ROUTER_NUM_OUT=4.
  - typedef enum logic {IDLE, LOCKED} sched_state_t.
- Sub-module rr_arbiter, purely combinational:
  - Inputs: req[NUM_REQ], ptr[$clog2(NUM_REQ)].
  - Outputs: onehot grant, index, any.
  - Instantiated once; the FSM, output register and rr_ptr live in router_rr_scheduler.

Test Plan:
- Reset, then req0 sends a 3-beat packet to addr=2 (data 0xA0, 0xA1, 0xA2) with out_ready=4'hF.
  - grant=0001 one cycle after req_valid.
  - din_en=1 for 3 consecutive cycles with addr=2.
  - Then IDLE, and rr_ptr=0.
- req1 and req3 each send a continuous stream of 1-beat packets; req0 and req2 stay idle.
  - Grants alternate 0010, 1000, 0010.
  - One idle (bubble) cycle between packets.
- Backpressure: req2 sends 2 beats (0x11, 0x22) to addr=1 with out_ready[1]=0 for 3 cycles.
  - din=0x11 and addr=1 held for 3 cycles.
  - req_ready[2]=0 while stalled.
  - 0x22 follows the cycle after out_ready[1] rises.
- Address lock: a packet whose req_addr changes 3 -> 0 on beat 2.
  - addr stays 3 for both beats.
- Reset asserted mid-packet, with din_en=1 and grant=0100.
  - At the next edge: din_en=0, din=0, grant=0, busy=0.
  - The next arbitration with all 4 requesters valid grants req0.
- Wrap: rr_ptr=3 with req0 and req3 valid.
  - req0 is granted first, then req3.
